// File: rtl/rk_dma_arbiter_if.sv
// Shared DMA port bundle: two disk-class masters on one side, the 18-bit memory port on the other.
// The "master" modport is the arbiter's view; "slave" is the surrounding masters/memory view.
interface rk_dma_arbiter_if;
  logic        dma_req0;
  logic        dma_req1;
  logic [17:0] dma_addr0;
  logic [17:0] dma_addr1;
  logic [15:0] dma_data_out0;
  logic [15:0] dma_data_out1;
  logic        dma_rd0;
  logic        dma_rd1;
  logic        dma_wr0;
  logic        dma_wr1;
  logic        dma_ack0;
  logic        dma_ack1;
  logic        mem_req;
  logic [17:0] mem_addr;
  logic [15:0] mem_data_out;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_ack;
  logic        clr_err;
  logic [1:0]  timeout;
  logic        busy;

  modport master (
    input  dma_req0, dma_req1, dma_addr0, dma_addr1,
    input  dma_data_out0, dma_data_out1,
    input  dma_rd0, dma_rd1, dma_wr0, dma_wr1,
    input  mem_ack, clr_err,
    output dma_ack0, dma_ack1,
    output mem_req, mem_addr, mem_data_out, mem_rd, mem_wr,
    output timeout, busy
  );

  modport slave (
    output dma_req0, dma_req1, dma_addr0, dma_addr1,
    output dma_data_out0, dma_data_out1,
    output dma_rd0, dma_rd1, dma_wr0, dma_wr1,
    output mem_ack, clr_err,
    input  dma_ack0, dma_ack1,
    input  mem_req, mem_addr, mem_data_out, mem_rd, mem_wr,
    input  timeout, busy
  );
endinterface

// File: rtl/rk_dma_arbiter.sv
// Two-master round-robin arbiter for the shared Unibus/memory DMA port, with a
// per-grant acknowledge timeout that aborts a stalled transfer and flags the master.
module rk_dma_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  rk_dma_arbiter_if.master bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg;
  logic        gnt_reg;
  logic        last_reg;
  logic [7:0]  cnt_reg;
  logic [1:0]  timeout_reg;
  logic [1:0]  timeout_next;

  logic [1:0]  req;
  logic [1:0]  rd;
  logic [1:0]  wr;
  logic [1:0]  ack;
  logic [17:0] addr  [2];
  logic [15:0] wdata [2];
  logic        granted;
  logic        abort;

  assign req      = {bus.dma_req1, bus.dma_req0};
  assign rd       = {bus.dma_rd1, bus.dma_rd0};
  assign wr       = {bus.dma_wr1, bus.dma_wr0};
  assign addr[0]  = bus.dma_addr0;
  assign addr[1]  = bus.dma_addr1;
  assign wdata[0] = bus.dma_data_out0;
  assign wdata[1] = bus.dma_data_out1;

  assign granted = (state_reg == GRANT);
  assign abort   = granted && req[gnt_reg] && !bus.mem_ack && (cnt_reg == CNT_LAST);

  // An abort in the same cycle as clr_err still leaves its flag set.
  always_comb begin
    timeout_next = bus.clr_err ? 2'b00 : timeout_reg;
    if (abort) begin
      timeout_next[gnt_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      gnt_reg     <= 1'b0;
      last_reg    <= 1'b1;
      cnt_reg     <= 8'd0;
      timeout_reg <= 2'b00;
    end else begin
      timeout_reg <= timeout_next;
      case (state_reg)
        IDLE: begin
          if (req != 2'b00) begin
            state_reg <= GRANT;
            gnt_reg   <= (req == 2'b11) ? ~last_reg : req[1];
            cnt_reg   <= 8'd0;
          end
        end
        GRANT: begin
          if (!req[gnt_reg]) begin
            last_reg  <= gnt_reg;
            state_reg <= IDLE;
          end else if (bus.mem_ack) begin
            cnt_reg <= 8'd0;
          end else if (cnt_reg == CNT_LAST) begin
            last_reg  <= gnt_reg;
            cnt_reg   <= 8'd0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Forwarding is combinational from the registered grant so acks carry no extra latency.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ack
      assign ack[gi] = granted && (gnt_reg == 1'(gi)) && bus.mem_ack;
    end
  endgenerate

  assign bus.dma_ack0     = ack[0];
  assign bus.dma_ack1     = ack[1];
  assign bus.mem_req      = granted && req[gnt_reg];
  assign bus.mem_addr     = granted ? addr[gnt_reg]  : 18'd0;
  assign bus.mem_data_out = granted ? wdata[gnt_reg] : 16'd0;
  assign bus.mem_rd       = granted && rd[gnt_reg];
  assign bus.mem_wr       = granted && wr[gnt_reg];
  assign bus.timeout      = timeout_reg;
  assign bus.busy         = granted;

endmodule

// File: tb/tb_rk_dma_arbiter.sv
// Directed bench for rk_dma_arbiter: a per-cycle vector table plus hand sequences
// for timeout, ack-on-last-count and asynchronous reset during a grant.
module tb_rk_dma_arbiter;

  localparam logic [17:0] A0  = 18'o001000;
  localparam logic [17:0] A1  = 18'o002000;
  localparam logic [15:0] D0  = 16'h1111;
  localparam logic [15:0] D1  = 16'h2222;
  localparam bit          RD0 = 1'b1;
  localparam bit          WR0 = 1'b0;
  localparam bit          RD1 = 1'b0;
  localparam bit          WR1 = 1'b1;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  rk_dma_arbiter_if bus ();

  rk_dma_arbiter #(.TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit       r0;
    bit       r1;
    bit       ack;
    bit       busy;
    bit       gnt;
    bit       mreq;
    bit       a0;
    bit       a1;
    logic [1:0] to;
  } vec_t;

  vec_t vecs [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected mux outputs are derived from the expected grant and the bench's own driven inputs.
  task automatic check_out(input string tag, input bit busy, input bit gnt, input bit mreq,
                           input bit a0, input bit a1, input logic [1:0] to);
    logic [17:0] e_addr;
    logic [15:0] e_data;
    bit          e_rd;
    bit          e_wr;
    e_addr = busy ? (gnt ? A1 : A0) : 18'd0;
    e_data = busy ? (gnt ? D1 : D0) : 16'd0;
    e_rd   = busy && (gnt ? RD1 : RD0);
    e_wr   = busy && (gnt ? WR1 : WR0);
    chk({tag, ".busy"},     32'(bus.busy),         32'(busy));
    chk({tag, ".mem_req"},  32'(bus.mem_req),      32'(mreq));
    chk({tag, ".ack0"},     32'(bus.dma_ack0),     32'(a0));
    chk({tag, ".ack1"},     32'(bus.dma_ack1),     32'(a1));
    chk({tag, ".timeout"},  32'(bus.timeout),      32'(to));
    chk({tag, ".mem_addr"}, 32'(bus.mem_addr),     32'(e_addr));
    chk({tag, ".mem_data"}, 32'(bus.mem_data_out), 32'(e_data));
    chk({tag, ".mem_rd"},   32'(bus.mem_rd),       32'(e_rd));
    chk({tag, ".mem_wr"},   32'(bus.mem_wr),       32'(e_wr));
    $display("%-12s req=%b%b ack=%b busy=%b mem_req=%b dma_ack=%b%b timeout=%b",
             tag, bus.dma_req1, bus.dma_req0, bus.mem_ack, bus.busy, bus.mem_req,
             bus.dma_ack1, bus.dma_ack0, bus.timeout);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle_inputs();
    bus.dma_req0      = 1'b0;
    bus.dma_req1      = 1'b0;
    bus.dma_addr0     = A0;
    bus.dma_addr1     = A1;
    bus.dma_data_out0 = D0;
    bus.dma_data_out1 = D1;
    bus.dma_rd0       = RD0;
    bus.dma_wr0       = WR0;
    bus.dma_rd1       = RD1;
    bus.dma_wr1       = WR1;
    bus.mem_ack       = 1'b0;
    bus.clr_err       = 1'b0;
  endtask

  task automatic do_reset();
    next_cycle();
    reset = 1'b0;
    drive_idle_inputs();
    next_cycle();
    reset = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    drive_idle_inputs();

    // Reset held with random inputs: every output must stay 0.
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      bus.dma_req0 = 1'($urandom);
      bus.dma_req1 = 1'($urandom);
      bus.mem_ack  = 1'($urandom);
      bus.clr_err  = 1'($urandom);
      bus.dma_addr0 = 18'($urandom);
      bus.dma_addr1 = 18'($urandom);
      #3;
      chk("rst.mem_req",  32'(bus.mem_req),  32'd0);
      chk("rst.mem_rd",   32'(bus.mem_rd),   32'd0);
      chk("rst.mem_wr",   32'(bus.mem_wr),   32'd0);
      chk("rst.mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst.acks",     32'({bus.dma_ack1, bus.dma_ack0}), 32'd0);
      chk("rst.timeout",  32'(bus.timeout),  32'd0);
      chk("rst.busy",     32'(bus.busy),     32'd0);
      $display("reset_rand   cycle %0d outputs checked", i);
    end
    drive_idle_inputs();

    //            rst r0 r1 ack  busy gnt mreq a0 a1 to
    vecs[0]  = '{1, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00};
    vecs[1]  = '{0, 1, 0, 0,   0, 0, 0, 0, 0, 2'b00};
    vecs[2]  = '{0, 1, 0, 0,   1, 0, 1, 0, 0, 2'b00};
    vecs[3]  = '{0, 1, 0, 0,   1, 0, 1, 0, 0, 2'b00};
    vecs[4]  = '{0, 1, 0, 0,   1, 0, 1, 0, 0, 2'b00};
    vecs[5]  = '{0, 1, 0, 1,   1, 0, 1, 1, 0, 2'b00};
    vecs[6]  = '{0, 0, 0, 0,   1, 0, 0, 0, 0, 2'b00};
    vecs[7]  = '{0, 0, 0, 1,   0, 0, 0, 0, 0, 2'b00};
    vecs[8]  = '{1, 1, 1, 0,   0, 0, 0, 0, 0, 2'b00};
    vecs[9]  = '{0, 1, 1, 0,   0, 0, 0, 0, 0, 2'b00};
    vecs[10] = '{0, 1, 1, 1,   1, 0, 1, 1, 0, 2'b00};
    vecs[11] = '{0, 0, 1, 0,   1, 0, 0, 0, 0, 2'b00};
    vecs[12] = '{0, 1, 1, 0,   0, 0, 0, 0, 0, 2'b00};
    vecs[13] = '{0, 1, 1, 1,   1, 1, 1, 0, 1, 2'b00};
    vecs[14] = '{0, 1, 0, 0,   1, 1, 0, 0, 0, 2'b00};
    vecs[15] = '{0, 1, 1, 0,   0, 0, 0, 0, 0, 2'b00};
    vecs[16] = '{0, 1, 1, 1,   1, 0, 1, 1, 0, 2'b00};
    vecs[17] = '{0, 0, 1, 0,   1, 0, 0, 0, 0, 2'b00};
    vecs[18] = '{0, 1, 1, 0,   0, 0, 0, 0, 0, 2'b00};
    vecs[19] = '{0, 1, 1, 1,   1, 1, 1, 0, 1, 2'b00};
    vecs[20] = '{0, 0, 0, 0,   1, 1, 0, 0, 0, 2'b00};
    vecs[21] = '{0, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00};

    for (int i = 0; i < 22; i++) begin
      next_cycle();
      reset        = vecs[i].rst ? 1'b0 : 1'b1;
      bus.dma_req0 = vecs[i].r0;
      bus.dma_req1 = vecs[i].r1;
      bus.mem_ack  = vecs[i].ack;
      #3;
      check_out($sformatf("vec%0d", i), vecs[i].busy, vecs[i].gnt, vecs[i].mreq,
                vecs[i].a0, vecs[i].a1, vecs[i].to);
    end

    // Timeout on master 1 while master 0 waits; master 0 gets the next grant.
    do_reset();
    bus.dma_req1 = 1'b1;
    #3;
    check_out("to.idle", 0, 0, 0, 0, 0, 2'b00);
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      if (k == 1) bus.dma_req0 = 1'b1;
      #3;
      check_out($sformatf("to.g%0d", k), 1, 1, 1, 0, 0, 2'b00);
    end
    next_cycle();
    #3;
    check_out("to.abort", 0, 0, 0, 0, 0, 2'b10);
    next_cycle();
    bus.mem_ack = 1'b1;
    #3;
    check_out("to.m0gnt", 1, 0, 1, 1, 0, 2'b10);
    next_cycle();
    bus.mem_ack  = 1'b0;
    bus.dma_req0 = 1'b0;
    #3;
    check_out("to.m0rel", 1, 0, 0, 0, 0, 2'b10);
    next_cycle();
    bus.dma_req1 = 1'b0;
    bus.clr_err  = 1'b1;
    #3;
    check_out("to.clr", 0, 0, 0, 0, 0, 2'b10);
    next_cycle();
    bus.clr_err = 1'b0;
    #3;
    check_out("to.cleared", 0, 0, 0, 0, 0, 2'b00);

    // Ack on the last count: no abort, and the counter restarts a full window.
    do_reset();
    bus.dma_req0 = 1'b1;
    #3;
    check_out("al.idle", 0, 0, 0, 0, 0, 2'b00);
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      bus.mem_ack = (k == 7);
      #3;
      check_out($sformatf("al.g%0d", k), 1, 0, 1, (k == 7), 0, 2'b00);
    end
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      bus.mem_ack = 1'b0;
      #3;
      check_out($sformatf("al.r%0d", k), 1, 0, 1, 0, 0, 2'b00);
    end
    next_cycle();
    bus.dma_req0 = 1'b0;
    #3;
    check_out("al.abort", 0, 0, 0, 0, 0, 2'b01);

    // Asynchronous reset during a master-1 write, then the first tie goes to master 0.
    do_reset();
    bus.dma_req1 = 1'b1;
    next_cycle();
    #3;
    check_out("rw.grant", 1, 1, 1, 0, 0, 2'b00);
    #2;
    reset = 1'b0;
    #1;
    chk("rw.mem_wr",  32'(bus.mem_wr),  32'd0);
    chk("rw.mem_req", 32'(bus.mem_req), 32'd0);
    chk("rw.busy",    32'(bus.busy),    32'd0);
    $display("rw.async     mem_wr=%b mem_req=%b busy=%b", bus.mem_wr, bus.mem_req, bus.busy);
    next_cycle();
    reset        = 1'b1;
    bus.dma_req0 = 1'b1;
    bus.dma_req1 = 1'b1;
    #3;
    check_out("rw.tie", 0, 0, 0, 0, 0, 2'b00);
    next_cycle();
    #3;
    check_out("rw.m0", 1, 0, 1, 0, 0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rk_dma_arbiter.md
# rk_dma_arbiter

Two-port round-robin arbiter that shares the single 18-bit Unibus/memory DMA port between two disk-class DMA masters, e.g. the RK11 IDE controller and a second block-device controller. Each master uses the same request/acknowledge protocol the RK controller already drives. The block also sequences the shared port: it holds one registered grant per transfer, muxes the granted master's address, data and strobes onto the memory side, and aborts a transfer that receives no memory acknowledge within a bounded time.

## Interface
Parameters:
- TIMEOUT, default 255: cycles a grant may wait for mem_ack before abort; legal range 2..255.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low (asserted when 0); clears all state immediately.
- dma_req0 / dma_req1  in  1  master N requests one word transfer; held until its ack, then dropped.
- dma_addr0 / dma_addr1  in  18  master N byte address.
- dma_data_out0 / dma_data_out1  in  16  master N write data.
- dma_rd0 / dma_rd1, dma_wr0 / dma_wr1  in  1  master N read/write strobes.
- dma_ack0 / dma_ack1  out  1  memory acknowledge routed to master N.
- mem_req  out  1  request to memory side.
- mem_addr  out  18  granted address.
- mem_data_out  out  16  granted write data.
- mem_rd, mem_wr  out  1  granted strobes.
- mem_ack  in  1  one-cycle completion from memory. Read data fans out to both masters outside this block.
- clr_err  in  1  clears timeout flags.
- timeout  out  2  sticky per-master abort flags.
- busy  out  1  a grant is active.

## Operation
- Two states: IDLE and GRANT. Registers: gnt (1 bit, index of granted master), last (1 bit, last master served), cnt (8 bits), timeout[1:0].
- IDLE:
  - If exactly one dma_reqN is high, load gnt=N and go to GRANT.
  - If both are high, load gnt=~last and go to GRANT.
  - If neither is high, stay in IDLE.
- GRANT, forwarding:
  - mem_req = dma_req[gnt].
  - mem_addr, mem_data_out, mem_rd and mem_wr = the granted master's inputs.
  - dma_ack[gnt] = mem_ack; the other ack is 0.
  - All forwarding is combinational from the registered gnt.
- GRANT, exit:
  - If dma_req[gnt] is low, load last=gnt and go to IDLE. This covers the normal release in the cycle after ack.
  - Otherwise, if mem_ack is high, clear cnt and stay in GRANT. Multiple acks per grant are allowed while req is held.
  - Otherwise, if cnt==TIMEOUT-1, set timeout[gnt], load last=gnt, clear cnt and go to IDLE (abort).
  - Otherwise, increment cnt.
- In IDLE, all mem_* outputs and both dma_ackN are 0. mem_ack received in IDLE is ignored.
- An aborted master that still requests re-enters arbitration. Round-robin gives the other master priority if it is requesting.
- clr_err clears both timeout bits. If a clr_err and an abort occur in the same cycle, the set wins.
- Reset values: state=IDLE, gnt=0, last=1 (master 0 wins the first tie), cnt=0, timeout=0. All outputs are 0.

## Timing
- Grant latency: dma_reqN sampled high in IDLE at edge k gives mem_req=1 from edge k onward. That is one clock of arbitration latency.
- Acknowledge: dma_ackN equals mem_ack in the same cycle, with no added latency.
- Release: the master drops req the cycle after ack. The arbiter returns to IDLE at the next edge. Minimum turnaround between grants is 1 idle cycle, so a back-to-back word costs ack + 2 cycles.
- Timeout: mem_req stays high for exactly TIMEOUT cycles without ack, then drops. The timeout bit is visible in the first IDLE cycle.
- mem_ack in the same cycle as cnt==TIMEOUT-1: the ack wins, and no abort occurs.
- Reset assertion mid-grant: all outputs go to 0 asynchronously, and the in-flight transfer is lost. Masters must themselves be reset.

## Test plan
- Reset: hold reset=0 with random inputs. mem_req=mem_rd=mem_wr=0, mem_addr=0, dma_ack0=dma_ack1=0, timeout=0, busy=0.
- Single read: dma_req0=1, dma_addr0=18'o001000, dma_rd0=1. Next cycle mem_req=1, mem_addr=o001000, mem_rd=1. After 3 cycles, pulse mem_ack: dma_ack0=1 in the same cycle. Drop req0: busy=0 one edge later.
- Tie after reset: req0 and req1 rise together. Master 0 is served first, then master 1.
- Fairness: repeat the tie for 4 rounds, with both masters re-requesting immediately after each ack. Grant order is 0,1,0,1 and dma_ack1 never pulses while gnt=0.
- Timeout with TIMEOUT=8: req1 held with no mem_ack. mem_req stays high for 8 cycles then drops, and timeout=2'b10. With req0 pending, the next grant goes to master 0. A clr_err pulse gives timeout=0.
- Ack on last count with TIMEOUT=8: mem_ack arrives on the 8th grant cycle. No abort, timeout stays 0, and cnt restarts.
- Reset mid-write: assert reset during GRANT with dma_wr1=1. mem_wr drops to 0 without waiting for clk, and after release the first tie goes to master 0.
